// File: rtl/ucr_hash_pkg.sv
// ucr_hash_pkg: shared constants and FSM encoding for the ucr hash core
package ucr_hash_pkg;
  localparam logic [7:0] H_INIT0 = 8'h01;
  localparam logic [7:0] H_INIT1 = 8'h89;
  localparam logic [7:0] H_INIT2 = 8'hfe;
  localparam logic [7:0] K_LO = 8'h99;
  localparam logic [7:0] K_HI = 8'ha1;
  localparam int N_ROUNDS = 32;
  localparam logic [4:0] K_SWITCH = 5'd16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/ucr_hash_round.sv
// ucr_hash_round: one combinational round of the ucr hash, shared with the miner
module ucr_hash_round
  import ucr_hash_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] w,
  input  logic [4:0] idx,
  output logic [7:0] a_n,
  output logic [7:0] b_n,
  output logic [7:0] c_n
);
  logic hi;
  assign hi = idx > K_SWITCH;
  assign a_n = b ^ c;
  assign b_n = {c[3:0], 4'h0};
  assign c_n = (hi ? (a | b) : (a ^ b)) + (hi ? K_HI : K_LO) + w;
endmodule

// File: rtl/nonce_verifier.sv
// nonce_verifier: recomputes the ucr hash of {payload,nonce} and checks claim and difficulty
module nonce_verifier
  import ucr_hash_pkg::*;
(
  input  logic        clk,
  input  logic        active,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [95:0] payload,
  input  logic [31:0] nonce,
  input  logic [23:0] hash_claim,
  input  logic [7:0]  target,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [23:0] hash_calc,
  output logic        hash_match,
  output logic        target_met,
  output logic        resp_ok
);
  logic [1:0]   state;
  logic [4:0]   cnt;
  logic [127:0] win;
  logic [7:0]   a, b, c, a_n, b_n, c_n, tgt;
  logic [23:0]  claim, h;
  logic         match_c, met_c;
  assign h = {H_INIT0 + a, H_INIT1 + b, H_INIT2 + c};
  assign match_c = h == claim;
  assign met_c = (h[23:16] < tgt) && (h[15:8] < tgt);
  ucr_hash_round u_round (
    .a(a), .b(b), .c(c), .w(win[127:120]), .idx(cnt),
    .a_n(a_n), .b_n(b_n), .c_n(c_n)
  );
  // request latch, 32 rounds over a byte-shift window, result register, response hold
  always_ff @(posedge clk or negedge active) begin
    if (!active) begin
      state <= S_IDLE;
      cnt <= '0;
      win <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      tgt <= '0;
      claim <= '0;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      hash_calc <= 24'hffffff;
      hash_match <= 1'b0;
      target_met <= 1'b0;
      resp_ok <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= !(req_valid && req_ready);
          if (req_valid && req_ready) begin
            state <= S_ROUND;
            cnt <= '0;
            win <= {payload, nonce};
            a <= H_INIT0;
            b <= H_INIT1;
            c <= H_INIT2;
            claim <= hash_claim;
            tgt <= target;
          end
        end
        S_ROUND: begin
          a <= a_n;
          b <= b_n;
          c <= c_n;
          win <= {win[119:0], win[23:16] | (win[71:64] ^ win[111:104])};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(N_ROUNDS - 1)) state <= S_FINAL;
        end
        S_FINAL: begin
          hash_calc <= h;
          hash_match <= match_c;
          target_met <= met_c;
          resp_ok <= match_c && met_c;
          state <= S_RESP;
        end
        default: begin
          if (!resp_valid) resp_valid <= 1'b1;
          else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready <= 1'b1;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_verifier.sv
// tb_nonce_verifier: directed self-checking bench for nonce_verifier
module tb_nonce_verifier;
  logic        clk = 1'b0;
  logic        active = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [95:0] payload = '0;
  logic [31:0] nonce = '0;
  logic [23:0] hash_claim = '0;
  logic [7:0]  target = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [23:0] hash_calc;
  logic        hash_match, target_met, resp_ok;
  int pass = 0;
  int total = 0;
  int lat;

  always #5 clk = ~clk;

  nonce_verifier dut (
    .clk(clk), .active(active), .req_valid(req_valid), .req_ready(req_ready),
    .payload(payload), .nonce(nonce), .hash_claim(hash_claim), .target(target),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .hash_calc(hash_calc),
    .hash_match(hash_match), .target_met(target_met), .resp_ok(resp_ok)
  );

  function automatic logic [23:0] golden(input logic [95:0] p, input logic [31:0] n);
    logic [127:0] blk;
    logic [7:0] w [32];
    logic [7:0] a, b, c, q, k, t;
    blk = {p, n};
    for (int j = 0; j < 16; j++) w[j] = blk[127-8*j -: 8];
    for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
    a = 8'h01; b = 8'h89; c = 8'hfe;
    for (int i = 0; i < 32; i++) begin
      q = (i <= 16) ? (a ^ b) : (a | b);
      k = (i <= 16) ? 8'h99 : 8'ha1;
      t = b ^ c;
      b = {c[3:0], 4'h0};
      c = q + k + w[i];
      a = t;
    end
    return {8'h01 + a, 8'h89 + b, 8'hfe + c};
  endfunction

  task automatic send(input logic [95:0] p, input logic [31:0] n, input logic [23:0] hc,
                      input logic [7:0] t, output int l);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL send_ready got=%b want=1", req_ready); else pass++;
    payload = p; nonce = n; hash_claim = hc; target = t; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; payload = ~p; nonce = ~n; hash_claim = ~hc; target = ~t;
    total++; if (req_ready !== 1'b0) $display("FAIL busy_ready got=%b want=0", req_ready); else pass++;
    l = 0;
    while (resp_valid !== 1'b1 && l < 100) begin
      @(posedge clk);
      @(negedge clk);
      l++;
    end
    total++; if (l !== 34) $display("FAIL latency got=%0d want=34", l); else pass++;
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if ({resp_valid, req_ready} !== 2'b01) $display("FAIL consume got=%b want=01", {resp_valid, req_ready});
    else pass++;
  endtask

  task automatic test_reset();
    active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, hash_calc, hash_match, target_met, resp_ok} !== {2'b00, 24'hffffff, 3'b000})
      $display("FAIL reset_vals got=%b%b %h %b%b%b want=00 ffffff 000", req_ready, resp_valid, hash_calc, hash_match, target_met, resp_ok);
    else pass++;
    active = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) $display("FAIL ready_before_edge got=%b want=0", req_ready); else pass++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, hash_calc} !== {2'b10, 24'hffffff})
      $display("FAIL release got=%b%b %h want=10 ffffff", req_ready, resp_valid, hash_calc);
    else pass++;
  endtask

  task automatic test_golden();
    send(96'h0, 32'h0, 24'hc18985, 8'hff, lat);
    total++;
    if ({hash_calc, hash_match, target_met, resp_ok} !== {24'hc18985, 3'b111})
      $display("FAIL golden got=%h %b%b%b want=c18985 111", hash_calc, hash_match, target_met, resp_ok);
    else pass++;
    consume();
  endtask

  task automatic test_mismatch();
    send(96'h0, 32'h0, 24'hc18984, 8'hff, lat);
    total++;
    if ({hash_calc, hash_match, target_met, resp_ok} !== {24'hc18985, 3'b010})
      $display("FAIL mismatch got=%h %b%b%b want=c18985 010", hash_calc, hash_match, target_met, resp_ok);
    else pass++;
    consume();
  endtask

  task automatic test_target();
    send(96'h0, 32'h0, 24'hc18985, 8'h00, lat);
    total++;
    if ({hash_match, target_met, resp_ok} !== 3'b100)
      $display("FAIL target_zero got=%b want=100", {hash_match, target_met, resp_ok});
    else pass++;
    consume();
    send(96'h0, 32'h0, 24'hc18985, 8'hc1, lat);
    total++;
    if ({hash_match, target_met, resp_ok} !== 3'b100)
      $display("FAIL target_equal got=%b want=100", {hash_match, target_met, resp_ok});
    else pass++;
    consume();
    send(96'h0, 32'h0, 24'hc18985, 8'hc2, lat);
    total++;
    if ({hash_match, target_met, resp_ok} !== 3'b111)
      $display("FAIL target_above got=%b want=111", {hash_match, target_met, resp_ok});
    else pass++;
    consume();
    send(96'h0, 32'h0, 24'hc18985, 8'h89, lat);
    total++;
    if ({hash_match, target_met, resp_ok} !== 3'b100)
      $display("FAIL target_mid_equal got=%b want=100", {hash_match, target_met, resp_ok});
    else pass++;
    consume();
  endtask

  task automatic test_stall();
    send(96'h0, 32'h0, 24'hc18985, 8'hff, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({resp_valid, req_ready, hash_calc, hash_match, target_met, resp_ok} !== {2'b10, 24'hc18985, 3'b111})
        $display("FAIL stall_%0d got=%b%b %h %b%b%b want=10 c18985 111", i, resp_valid, req_ready, hash_calc, hash_match, target_met, resp_ok);
      else pass++;
    end
    consume();
    total++;
    if ({hash_calc, hash_match, target_met, resp_ok} !== {24'hc18985, 3'b111})
      $display("FAIL idle_retain got=%h %b%b%b want=c18985 111", hash_calc, hash_match, target_met, resp_ok);
    else pass++;
  endtask

  task automatic test_model(input logic [95:0] p, input logic [31:0] n, input logic [7:0] t);
    logic [23:0] e;
    logic m;
    e = golden(p, n);
    m = (e[23:16] < t) && (e[15:8] < t);
    send(p, n, e, t, lat);
    total++;
    if ({hash_calc, hash_match, target_met, resp_ok} !== {e, 1'b1, m, m})
      $display("FAIL model got=%h %b%b%b want=%h 1%b%b", hash_calc, hash_match, target_met, resp_ok, e, m, m);
    else pass++;
    consume();
  endtask

  task automatic test_abort();
    @(negedge clk);
    payload = 96'h0; nonce = 32'h0; hash_claim = 24'hc18985; target = 8'hff; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    active = 1'b0;
    #1;
    total++;
    if ({req_ready, resp_valid, hash_calc} !== {2'b00, 24'hffffff})
      $display("FAIL abort_clear got=%b%b %h want=00 ffffff", req_ready, resp_valid, hash_calc);
    else pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    active = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid} !== 2'b10) $display("FAIL abort_release got=%b want=10", {req_ready, resp_valid});
    else pass++;
    test_model(96'h0123456789abcdef01234567, 32'hdeadbeef, 8'hff);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_target();
    test_stall();
    test_model(96'hffffffffffffffffffffffff, 32'h00000001, 8'hf0);
    test_model(96'h8040201008040201a5a55a5a, 32'h12345678, 8'h80);
    test_abort();
    test_model(96'hcafef00d0badc0de13579bdf, 32'h2468ace0, 8'hff);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/nonce_verifier.md
NONCE_VERIFIER -- requirements
Module: nonce_verifier

Interface
REQ-001 Parameters: none; all algorithm constants SHALL come from the shared package.
REQ-002 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock for all state.
REQ-003 active  input  1  asynchronous active-low reset; 0 clears all state immediately.
REQ-004 req_valid  input  1  a verification request is presented.
REQ-005 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 payload  input  96  claimed payload, sampled at acceptance.
REQ-007 nonce  input  32  claimed nonce, sampled at acceptance.
REQ-008 hash_claim  input  24  claimed hash {h0,h1,h2}, sampled at acceptance.
REQ-009 target  input  8  difficulty target, sampled at acceptance.
REQ-010 resp_valid  output  1  result fields are valid.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 hash_calc  output  24  hash recomputed from {payload,nonce}.
REQ-013 hash_match  output  1  hash_calc == hash_claim.
REQ-014 target_met  output  1  hash_calc[23:16] < target AND hash_calc[15:8] < target (unsigned).
REQ-015 resp_ok  output  1  hash_match AND target_met.

Function
REQ-016 Handshake: a request SHALL be accepted on a rising edge where req_valid && req_ready; inputs SHALL then be latched, and later input changes SHALL be ignored.
REQ-017 FSM states: IDLE -> ROUND on acceptance; ROUND (round counter 0..31) -> FINAL after round 31; FINAL -> RESP; RESP -> IDLE on the edge where resp_ready=1.
REQ-018 Block bytes: w[0]=block[127:120] ... w[15]=block[7:0], where block={payload,nonce}.
REQ-019 Schedule: 16-byte shift window; each round consumes window[0] and shifts in window[13] | (window[7] ^ window[2]), giving w[j]=w[j-3]|(w[j-9]^w[j-14]) for j=16..31.
REQ-020 Init: a=8'h01, b=8'h89, c=8'hfe at acceptance.
REQ-021 Round i (one per clock): for i<=16, k=8'h99 and q=a^b; for i>=17, k=8'ha1 and q=a|b; then a'=b^c, b'=(c<<4) truncated to 8 bits, c'=q+k+w[i] mod 256.
REQ-022 FINAL: hash_calc={8'h01+a, 8'h89+b, 8'hfe+c}, each sum mod 256; hash_match, target_met and resp_ok SHALL be registered in the same edge.
REQ-023 Latency: resp_valid SHALL rise exactly 34 edges after the acceptance edge (32 ROUND edges, 1 FINAL edge, 1 edge into RESP).
REQ-024 In RESP, resp_valid and all result fields SHALL be held stable until resp_ready=1; resp_valid SHALL drop on the following edge.
REQ-025 req_ready SHALL be 0 in ROUND, FINAL and RESP; a request cannot be accepted on the same edge that leaves RESP, so back-to-back spacing is at least 36 edges.
REQ-026 Result fields SHALL retain their last values in IDLE; only resp_valid qualifies them.
REQ-027 target=0: target_met and resp_ok SHALL be 0 regardless of the hash.

Reset
REQ-028 While active=0: state=IDLE, round counter=0, window=0, a/b/c=0, req_ready=0, resp_valid=0, hash_calc=24'hffffff, hash_match=0, target_met=0, resp_ok=0.
REQ-029 req_ready SHALL rise on the first rising edge after active deasserts.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no response SHALL be produced for the aborted request.

Structure
REQ-031 Shared package ucr_hash_pkg SHALL hold H_INIT0/1/2 (8'h01, 8'h89, 8'hfe), K_LO=8'h99, K_HI=8'ha1, N_ROUNDS=32, K_SWITCH=16, and the FSM state encoding.
REQ-032 One combinational sub-module, ucr_hash_round (inputs a, b, c, w, round index; outputs a', b', c'), SHALL implement REQ-021 and be reusable by the miner.

Verification
REQ-033 Reset then release, with no request -> hash_calc=24'hffffff, resp_valid=0, req_ready=1 one edge after release.
REQ-034 payload=96'h0, nonce=32'h0, hash_claim equal to the C golden model output, target=8'hff -> resp_valid at edge 34, hash_match=1, target_met=1, resp_ok=1.
REQ-035 Same request with hash_claim bit 0 flipped -> hash_match=0, resp_ok=0, hash_calc unchanged.
REQ-036 Golden-model pair with target=8'h00 -> target_met=0, resp_ok=0; with target equal to hash_calc[23:16] -> target_met=0.
REQ-037 resp_ready held 0 for 10 cycles in RESP -> outputs stable and req_ready=0 throughout; on release, IDLE one edge later.
REQ-038 active pulsed low at round 15, then a new request -> no stale response; the new result matches the golden model at edge 34.
